// File: rtl/spatial_mac_pipe.sv
// Pipelined fusible-precision dot-product MAC: register -> lane products/adder tree -> accumulate -> out.
// Lane width follows the wider of the two runtime operand widths; narrower operand uses the low bits of each lane.
module spatial_mac_pipe #(
  parameter int PRECISION   = 16,
  parameter int L_PRECISION = 2,
  parameter int ACC_WIDTH   = 48,
  parameter int NUM_LEVELS  = $clog2(PRECISION / L_PRECISION),
  parameter int SEL_W       = $clog2(NUM_LEVELS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] a,
  input  logic [PRECISION-1:0] b,
  input  logic [SEL_W-1:0]     a_sel,
  input  logic [SEL_W-1:0]     b_sel,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic                 acc_first,
  input  logic                 acc_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out
);

  localparam int N_MAX  = 1 << NUM_LEVELS;
  localparam int EL_W   = PRECISION + 1;
  localparam int PROD_W = 2 * EL_W;
  localparam int SUM_W  = 2 * PRECISION + NUM_LEVELS + 2;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = reset & ~stall;

  // S1 registers
  logic                 v1, sa_r, sb_r, first1, last1;
  logic [PRECISION-1:0] a_r, b_r;
  logic [SEL_W-1:0]     asel_r, bsel_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      asel_r <= '0;
      bsel_r <= '0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        a_r    <= a;
        b_r    <= b;
        asel_r <= a_sel;
        bsel_r <= b_sel;
        sa_r   <= a_signed;
        sb_r   <= b_signed;
        first1 <= acc_first;
        last1  <= acc_last;
      end
    end
  end

  // Selects beyond the finest level clamp to L_PRECISION-wide elements.
  logic [SEL_W-1:0] la, lb, ll;
  assign la = (asel_r > SEL_W'(NUM_LEVELS)) ? SEL_W'(NUM_LEVELS) : asel_r;
  assign lb = (bsel_r > SEL_W'(NUM_LEVELS)) ? SEL_W'(NUM_LEVELS) : bsel_r;
  assign ll = (la < lb) ? la : lb;

  function automatic logic signed [EL_W-1:0] ext_el(input logic [PRECISION-1:0] v,
                                                   input int w, input logic sgn);
    logic [EL_W-1:0] m;
    logic [EL_W-1:0] r;
    logic [EL_W-1:0] sh;
    m  = (EL_W'(1) << w) - EL_W'(1);
    r  = {1'b0, v} & m;
    sh = {1'b0, v} >> (w - 1);
    if (sgn && sh[0]) r = r | ~m;
    return $signed(r);
  endfunction

  int                       wa, wb, lw, nl;
  logic signed [EL_W-1:0]   ea, eb;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum_c;

  always_comb begin
    wa    = PRECISION >> la;
    wb    = PRECISION >> lb;
    lw    = PRECISION >> ll;
    nl    = 1 << ll;
    ea    = '0;
    eb    = '0;
    prod  = '0;
    sum_c = '0;
    for (int i = 0; i < N_MAX; i++) begin
      ea   = ext_el(a_r >> (i * lw), wa, sa_r);
      eb   = ext_el(b_r >> (i * lw), wb, sb_r);
      prod = ea * eb;
      if (i < nl) sum_c = sum_c + SUM_W'(prod);
    end
  end

  // S2 registers
  logic                    v2, first2, last2;
  logic signed [SUM_W-1:0] sum_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2     <= 1'b0;
      sum_r  <= '0;
      first2 <= 1'b0;
      last2  <= 1'b0;
    end else if (!stall) begin
      v2 <= v1;
      if (v1) begin
        sum_r  <= sum_c;
        first2 <= first1;
        last2  <= last1;
      end
    end
  end

  // S3 accumulate, then the out register picks up the finished group one edge later.
  logic                 v3, last3;
  logic [ACC_WIDTH-1:0] acc, sum_ext;
  assign sum_ext = ACC_WIDTH'(sum_r);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3        <= 1'b0;
      last3     <= 1'b0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      v3 <= v2;
      if (v2) begin
        acc   <= first2 ? sum_ext : acc + sum_ext;
        last3 <= last2;
      end
      if (v3 && last3) begin
        out       <= acc;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
